// File: rtl/line_memory_pkg.sv
// rtl/line_memory_pkg.sv - shared cache/memory types and line geometry
package line_memory_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned LINE_W     = 128;
  localparam int unsigned LINE_BYTES = 16;
  localparam int unsigned LINE_OFF_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    INIT = 2'd3
  } mem_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
    logic              rw;
    logic              valid;
  } mem_req_t;

  typedef struct packed {
    logic [LINE_W-1:0] data;
    logic              ready;
  } mem_resp_t;

endpackage

// File: rtl/line_memory_array.sv
// rtl/line_memory_array.sv - single-port line RAM with registered read
module line_memory_array
  import line_memory_pkg::*;
#(
  parameter int unsigned DEPTH_LINES = 1024,
  parameter int unsigned IDX_W       = $clog2(DEPTH_LINES)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] mem_q [DEPTH_LINES];
  logic [LINE_W-1:0] rdata_q;

  // One access per edge: a write updates the line, otherwise the line is read out
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end else begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/line_memory.sv
// rtl/line_memory.sv - fixed-latency line memory behind the cache controller (option: LINE_MEMORY_ZERO_INIT_EN)
module line_memory
  import line_memory_pkg::*;
#(
  parameter int unsigned DEPTH_LINES = 1024,
  parameter int unsigned LATENCY     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] mem_req_addr,
  input  logic [LINE_W-1:0] mem_req_data,
  input  logic              mem_req_rw,
  input  logic              mem_req_valid,
  output logic [LINE_W-1:0] mem_resp_data,
  output logic              mem_resp_ready
);

  localparam int unsigned IDX_W = $clog2(DEPTH_LINES);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              rw_q, rw_d;
  mem_resp_t         resp_q, resp_d;

  logic              ram_we;
  logic [IDX_W-1:0]  ram_idx;
  logic [LINE_W-1:0] ram_wdata;
  logic [LINE_W-1:0] ram_rdata;
  logic [IDX_W-1:0]  req_idx;

`ifdef LINE_MEMORY_ZERO_INIT_EN
  logic [IDX_W-1:0]  init_q, init_d;
`endif

  // Offset bits and the aliased upper bits do not select anything
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_req_addr[ADDR_W-1:LINE_OFF_W+IDX_W],
                              mem_req_addr[LINE_OFF_W-1:0]};

  assign req_idx = mem_req_addr[LINE_OFF_W +: IDX_W];

  line_memory_array #(
    .DEPTH_LINES (DEPTH_LINES),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk_i   (clk),
    .we_i    (ram_we),
    .idx_i   (ram_idx),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // Next state: the RAM reads every non-write cycle, so its output is valid at the
  // access edge; in IDLE it follows the live address so LATENCY=1 still works
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    rw_d         = rw_q;
    resp_d.data  = resp_q.data;
    resp_d.ready = 1'b0;
    ram_we       = 1'b0;
    ram_idx      = idx_q;
    ram_wdata    = wdata_q;
`ifdef LINE_MEMORY_ZERO_INIT_EN
    init_d       = init_q;
`endif
    case (state_q)
      IDLE: begin
        ram_idx = req_idx;
        if (mem_req_valid) begin
          idx_d   = req_idx;
          wdata_d = mem_req_data;
          rw_d    = mem_req_rw;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d      = RESP;
          resp_d.ready = 1'b1;
          if (rw_q) begin
            ram_we = 1'b1;
          end else begin
            resp_d.data = ram_rdata;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
`ifdef LINE_MEMORY_ZERO_INIT_EN
      INIT: begin
        ram_we    = 1'b1;
        ram_idx   = init_q;
        ram_wdata = '0;
        init_d    = init_q + IDX_W'(1);
        if (init_q == IDX_W'(DEPTH_LINES - 1)) begin
          state_d = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, request latches and registered response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
`ifdef LINE_MEMORY_ZERO_INIT_EN
      state_q <= INIT;
      init_q  <= '0;
`else
      state_q <= IDLE;
`endif
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      resp_q  <= '0;
    end else begin
`ifdef LINE_MEMORY_ZERO_INIT_EN
      init_q  <= init_d;
`endif
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      resp_q  <= resp_d;
    end
  end

  assign mem_resp_data  = resp_q.data;
  assign mem_resp_ready = resp_q.ready;

endmodule

// File: doc/line_memory.md
# line_memory

Line-granular backing memory that sits directly downstream of `cache_controller`. It consumes the controller's `mem_req` channel (32-bit address, 128-bit line, rw, valid) and answers on the `mem_resp` channel (128-bit data, ready) after a fixed, parameterised latency. It serves as the main-memory model in cache DV benches and as the reference timing model for the refill and write-back paths.

## Interface
- `DEPTH_LINES`, 1024: number of 16-byte lines; power of two, ≥2; `IDX_W = $clog2(DEPTH_LINES)`.
- `LATENCY`, 4: cycles from request acceptance to the response pulse; ≥1.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `mem_req_addr` in 32: byte address; `[3:0]` ignored, line index is `[4+IDX_W-1:4]`, upper bits ignored (aliasing).
- `mem_req_data` in 128: write line.
- `mem_req_rw` in 1: 1 = write, 0 = read.
- `mem_req_valid` in 1: request present; the requester holds it until it sees `mem_resp_ready`.
- `mem_resp_data` out 128: read line; registered, holds its value between read responses.
- `mem_resp_ready` out 1: one-cycle completion pulse for reads and writes.

## Operation
- Reset values: `mem_resp_ready`=0, `mem_resp_data`=0, FSM in IDLE, counter 0. Array contents are not reset, except as described under Configuration.
- FSM states: IDLE, WAIT, RESP.
- **IDLE → WAIT:** taken on a rising edge with `mem_req_valid`=1.
  - Latch `addr`, `data` and `rw` into internal registers.
  - Load the counter with `LATENCY-1`.
  - Request inputs are not sampled again until the FSM next reaches IDLE.
- **WAIT:**
  - Counter ≠0: decrement.
  - Counter =0: move to RESP.
  - On that same edge, perform the access using the latched fields. A write updates the line. A read loads `mem_resp_data` from the line (read-before-write is not applicable, since there is one access per request).
- **RESP:** `mem_resp_ready`=1 for exactly this cycle, then unconditionally IDLE.
  - A `mem_req_valid` still seen high during RESP belongs to the completed request and is ignored.
- **Writes:** `mem_resp_data` keeps the previous read value.
- **Back-to-back requests** (for example write-back followed immediately by allocate): the requester changes fields on the edge that ends RESP. The new request is accepted at the end of the following IDLE cycle.
- **Reset asserted mid-request:** the request is abandoned, with no response pulse. A write is committed only if its commit edge occurred before reset asserted.
- **Undefined-but-safe inputs:** X or changing `mem_req_*` while in WAIT or RESP has no effect.

## Timing
- Acceptance edge E0 → access edge E0+LATENCY → `mem_resp_ready` high in the cycle after E0+LATENCY.
- Response latency: LATENCY cycles from acceptance.
- Throughput: one request per LATENCY+2 cycles (ready cycle plus one IDLE cycle).
- `LATENCY`=1: WAIT lasts one cycle; ready is high in the cycle after E0+1.
- All outputs are registered; no combinational path from `mem_req_*` to outputs.

## Configuration
- Macro: `LINE_MEMORY_ZERO_INIT_EN`.
- **Defined:**
  - After reset deasserts, the block enters INIT and writes zero to lines 0..`DEPTH_LINES-1`, one line per cycle.
  - No request is accepted during INIT; `mem_resp_ready` stays 0 and a pending valid simply waits.
  - INIT → IDLE after the last line is written, so the first acceptance is possible at edge `DEPTH_LINES`+1.
  - Reset during INIT restarts the sweep.
- **Undefined:** no INIT state; contents are unknown until written; the first acceptance is possible on the first edge after reset deassertion.

## Structure
- Shared cache package additions:
  - `LINE_BYTES`=16 and `LINE_OFF_W`=4.
  - A `mem_state_e` enum (IDLE, WAIT, RESP, INIT).
  - Reuse the existing `mem_req_t` / `mem_resp_t` field widths.
- Sub-module `line_memory_array`: single-port synchronous RAM, `DEPTH_LINES`×128.
  - Ports: write enable, index, wdata, rdata.
  - Registered read; the FSM times its read-enable so rdata lands at the access edge.
- Top level: FSM, latency counter, request latches, INIT sweep counter.

## Test plan
- **Write then read:** write 0x0123…CDEF to addr 0x0000_0040, then read 0x0000_0040 → ready pulses exactly 4 cycles after each acceptance; read returns 0x0123…CDEF.
- **Offset and alias:** write line A at 0x10, then read 0x1F and 0x10+16·DEPTH_LINES → both return A.
- **Back-to-back with valid held through RESP:**
  - Write-back to 0x100, then immediately read 0x200 → both serviced once, no duplicate response.
  - Spacing between ready pulses = LATENCY+2 = 6 cycles.
- **Minimum latency:** `LATENCY`=1, read → ready in the cycle after acceptance+1; a write leaves `mem_resp_data` unchanged.
- **Mid-operation reset:** write to 0x80 accepted, reset pulsed during WAIT → no ready pulse; a later read of 0x80 returns the old contents; outputs are 0 during reset.
- **With `LINE_MEMORY_ZERO_INIT_EN`:** valid held from reset release → no acceptance before edge `DEPTH_LINES`+1; a read of any address returns 0.
